// File: rtl/max_pool_layer.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream, one pixel per accepted cycle.
// Each channel is pooled independently using signed comparison at full WIDTH.
// Even-column pixels park in a hold register. Odd columns form a horizontal pair maximum.
// On even rows the pair maximum goes to a half-width line buffer. On odd rows it is
// merged with the stored value from the row above and registered as the output.
// Optional feature: define MAX_POOL_RELU_EN to clamp negative output channels to zero (fused ReLU).
module max_pool_layer #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned CHANNELS     = 5,
   parameter int unsigned IMAGE_WIDTH  = 60,
   parameter int unsigned IMAGE_HEIGHT = 28
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clk_en,
   input  logic [CHANNELS*WIDTH-1:0] input_data,
   input  logic                      input_valid,
   output logic [CHANNELS*WIDTH-1:0] output_data,
   output logic                      output_valid
);

   localparam int unsigned DATA_W   = CHANNELS * WIDTH;
   localparam int unsigned COL_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int unsigned ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int unsigned LB_DEPTH = IMAGE_WIDTH / 2;
   localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   // Per-channel signed maximum of two packed pixels; ties return either (identical) value.
   function automatic logic [DATA_W-1:0] pix_max(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if ($signed(a[c*WIDTH +: WIDTH]) >= $signed(b[c*WIDTH +: WIDTH])) begin
            r[c*WIDTH +: WIDTH] = a[c*WIDTH +: WIDTH];
         end else begin
            r[c*WIDTH +: WIDTH] = b[c*WIDTH +: WIDTH];
         end
      end
      return r;
   endfunction

`ifdef MAX_POOL_RELU_EN
   // Clamp each negative channel to zero.
   function automatic logic [DATA_W-1:0] pix_relu(input logic [DATA_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = a;
      for (int c = 0; c < CHANNELS; c++) begin
         if (a[c*WIDTH + WIDTH - 1]) begin
            r[c*WIDTH +: WIDTH] = '0;
         end
      end
      return r;
   endfunction
`endif

   logic [COL_W-1:0]  col_q, col_next;
   logic [ROW_W-1:0]  row_q, row_next;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] line_buf [LB_DEPTH];

   logic              accept;
   logic              odd_col, odd_row;
   logic [LB_AW-1:0]  lb_idx;
   logic [DATA_W-1:0] lb_rd;
   logic [DATA_W-1:0] pair_max;
   logic [DATA_W-1:0] win_max;
   logic [DATA_W-1:0] pool_out;

   assign accept  = clk_en && input_valid;
   assign odd_col = col_q[0];
   assign odd_row = row_q[0];
   assign lb_idx  = LB_AW'(col_q >> 1);
   assign lb_rd   = line_buf[lb_idx];

   // Next column/row position after an accepted pixel, wrapping at row and frame ends.
   always_comb begin
      col_next = col_q;
      row_next = row_q;
      if (col_q == COL_W'(IMAGE_WIDTH - 1)) begin
         col_next = '0;
         if (row_q == ROW_W'(IMAGE_HEIGHT - 1)) begin
            row_next = '0;
         end else begin
            row_next = row_q + 1'b1;
         end
      end else begin
         col_next = col_q + 1'b1;
      end
   end

   // Horizontal pair maximum, vertical merge with the buffered row, optional ReLU.
   always_comb begin
      pair_max = pix_max(hold_q, input_data);
      win_max  = pix_max(pair_max, lb_rd);
`ifdef MAX_POOL_RELU_EN
      pool_out = pix_relu(win_max);
`else
      pool_out = win_max;
`endif
   end

   // Position counters, hold register and registered output; reset wins over clk_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         output_data  <= '0;
         output_valid <= 1'b0;
      end else if (clk_en) begin
         output_valid <= 1'b0;
         if (input_valid) begin
            col_q <= col_next;
            row_q <= row_next;
            if (!odd_col) begin
               hold_q <= input_data;
            end else if (odd_row) begin
               output_data  <= pool_out;
               output_valid <= 1'b1;
            end
         end
      end
   end

   // Line buffer: written on even-row, odd-column pixels; no reset since reads follow writes.
   always_ff @(posedge clk) begin
      if (!rst && accept && odd_col && !odd_row) begin
         line_buf[lb_idx] <= pair_max;
      end
   end

endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer at WIDTH=16, CHANNELS=2, 4x4 image.
module tb_max_pool_layer;

   localparam int unsigned WIDTH    = 16;
   localparam int unsigned CHANNELS = 2;

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic [31:0] input_data;
   logic        input_valid;
   logic [31:0] output_data;
   logic        output_valid;

   int unsigned checks;
   int unsigned errors;

   logic [31:0] got [$];
   logic        mon_en;
   logic        gap_mode;
   logic        prev_v;
   logic        en_s;
   logic        rst_s;

`ifdef MAX_POOL_RELU_EN
   localparam logic [31:0] NEG_FIRST = 32'h0000_0000;
   localparam logic [31:0] NEG_REST  = 32'h0000_0000;
`else
   localparam logic [31:0] NEG_FIRST = 32'hFFFF_FFFF;
   localparam logic [31:0] NEG_REST  = 32'hFFFD_FFFD;
`endif

   max_pool_layer #(
      .WIDTH        (WIDTH),
      .CHANNELS     (CHANNELS),
      .IMAGE_WIDTH  (4),
      .IMAGE_HEIGHT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .input_data   (input_data),
      .input_valid  (input_valid),
      .output_data  (output_data),
      .output_valid (output_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Collect one output per enabled edge with output_valid high; optionally flag back-to-back pulses.
   always begin
      @(posedge clk);
      en_s  = clk_en;
      rst_s = rst;
      #1;
      if (mon_en && en_s && !rst_s && output_valid) got.push_back(output_data);
      if (gap_mode) check("gap_no_consec", {31'b0, prev_v & output_valid}, 32'd0);
      prev_v = output_valid;
   end

   // Drive one cycle at the falling edge, return just after the following rising edge.
   task automatic cycle(input logic v, input logic [15:0] c0, input logic [15:0] c1);
      @(negedge clk);
      clk_en      = 1'b1;
      input_valid = v;
      input_data  = {c0, c1};
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst         = 1'b1;
      input_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_frame();
      apply_reset();
      got.delete();
      mon_en = 1'b1;
   endtask

   task automatic compare4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] exp [4];
      exp = '{e0, e1, e2, e3};
      check({tag, "_count"}, got.size(), 32'd4);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         check($sformatf("%s_out%0d", tag, i), got[i], exp[i]);
      end
   endtask

   task automatic ramp(input logic gaps);
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 16'(k), 16'(k));
         if (gaps) cycle(1'b0, 16'h0, 16'h0);
      end
      cycle(1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clk         = 1'b0;
      rst         = 1'b0;
      clk_en      = 1'b1;
      input_valid = 1'b0;
      input_data  = '0;
      mon_en      = 1'b0;
      gap_mode    = 1'b0;
      prev_v      = 1'b0;
      checks      = 0;
      errors      = 0;

      // Reset must clear state even with clk_en low.
      @(negedge clk);
      rst    = 1'b1;
      clk_en = 1'b0;
      @(negedge clk);
      check("rst_valid", {31'b0, output_valid}, 32'd0);
      check("rst_data", output_data, 32'd0);
      rst    = 1'b0;
      clk_en = 1'b1;

      // Ramp with per-pixel latency check.
      start_frame();
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 16'(k), 16'(k));
         check($sformatf("ramp_lat_px%0d", k), {31'b0, output_valid},
               {31'b0, (k == 5 || k == 7 || k == 13 || k == 15)});
      end
      cycle(1'b0, 16'h0, 16'h0);
      check("ramp_idle_valid", {31'b0, output_valid}, 32'd0);
      compare4("ramp", 32'h0005_0005, 32'h0007_0007, 32'h000D_000D, 32'h000F_000F);

      // Negative values.
      start_frame();
      for (int k = 0; k < 16; k++) begin
         if (k == 4) cycle(1'b1, 16'hFFFF, 16'hFFFF);
         else        cycle(1'b1, 16'hFFFD, 16'hFFFD);
      end
      cycle(1'b0, 16'h0, 16'h0);
      compare4("neg", NEG_FIRST, NEG_REST, NEG_REST, NEG_REST);

      // Ramp with input_valid toggling.
      start_frame();
      gap_mode = 1'b1;
      ramp(1'b1);
      gap_mode = 1'b0;
      compare4("gaps", 32'h0005_0005, 32'h0007_0007, 32'h000D_000D, 32'h000F_000F);

      // Stall for three cycles right after pixel 5.
      start_frame();
      for (int k = 0; k < 6; k++) cycle(1'b1, 16'(k), 16'(k));
      @(negedge clk);
      clk_en      = 1'b0;
      input_valid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall%0d_valid", s), {31'b0, output_valid}, 32'd1);
         check($sformatf("stall%0d_data", s), output_data, 32'h0005_0005);
      end
      for (int k = 6; k < 16; k++) cycle(1'b1, 16'(k), 16'(k));
      cycle(1'b0, 16'h0, 16'h0);
      compare4("stall", 32'h0005_0005, 32'h0007_0007, 32'h000D_000D, 32'h000F_000F);

      // Mid-frame reset after pixel 6, then a full frame.
      apply_reset();
      mon_en = 1'b0;
      for (int k = 0; k < 7; k++) cycle(1'b1, 16'(k), 16'(k));
      start_frame();
      check("midrst_valid", {31'b0, output_valid}, 32'd0);
      ramp(1'b0);
      compare4("midrst", 32'h0005_0005, 32'h0007_0007, 32'h000D_000D, 32'h000F_000F);

      // Channel independence.
      start_frame();
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, (k == 0) ? 16'd100 : 16'd0, (k == 15) ? 16'd200 : 16'd0);
      end
      cycle(1'b0, 16'h0, 16'h0);
      compare4("chan", 32'h0064_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_00C8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
